// File: rtl/coherence_bus_ctrl.sv
// ---------------------------------------------------------------------------
// coherence_bus_ctrl
//
// Purpose:
//   Snooping bus controller shared by two cores. It sits between both L1
//   dcache control FSMs, both icaches and a single-port RAM. It arbitrates
//   requests, snoops the peer dcache when a requester misses, and forwards
//   dirty peer data cache-to-cache while writing it back to RAM in the same
//   cycle. It also serves plain writebacks and instruction fetches.
//   Invalidation is MSI-style through ccinv.
//
// Parameters:
//   ADDR_W   address/data width
//   RR_INIT  core given priority first after reset
//
// Ports:
//   CLK, nRST            clock (rising edge) and asynchronous active-low reset
//   dREN/dWEN [1:0]      per-core dcache read/write request
//   daddr/dstore         per-core dcache word address / write data
//   cctrans [1:0]        requester has a coherence miss transaction pending
//   ccwrite [1:0]        requester: wants exclusive;
//                        snoopee during SNOOP: block is dirty and it will supply
//   iREN/iaddr           per-core instruction fetch request / address
//   ramload, ramwait     RAM read data; ramwait low means the access completes
//   dwait/iwait [1:0]    per-core stall, low only in the completing cycle
//   dload/iload          per-core returned data, valid while the wait is low
//   ccwait [1:0]         snoop request to a core (it stalls its own traffic)
//   ccsnoopaddr          snoop address per core, 0 when not snooped
//   ccinv [1:0]          invalidate the snooped block
//   ramREN/ramWEN        RAM strobes, never both high
//   ramaddr/ramstore     RAM address / write data
//
// Optional feature (macro BUS_STATS_EN):
//   Adds c2c_cnt, ram_rd_cnt, ram_wr_cnt outputs: saturating counters of
//   completed cache-to-cache words, RAM read words and RAM write words.
//   They are cleared only by nRST.
// ---------------------------------------------------------------------------
module coherence_bus_ctrl #(
  parameter int   ADDR_W  = 32,
  parameter logic RR_INIT = 1'b0
) (
  input  logic                   CLK,
  input  logic                   nRST,
  input  logic [1:0]             dREN,
  input  logic [1:0]             dWEN,
  input  logic [1:0][ADDR_W-1:0] daddr,
  input  logic [1:0][ADDR_W-1:0] dstore,
  input  logic [1:0]             cctrans,
  input  logic [1:0]             ccwrite,
  input  logic [1:0]             iREN,
  input  logic [1:0][ADDR_W-1:0] iaddr,
  input  logic [ADDR_W-1:0]      ramload,
  input  logic                   ramwait,
  output logic [1:0]             dwait,
  output logic [1:0]             iwait,
  output logic [1:0][ADDR_W-1:0] dload,
  output logic [1:0][ADDR_W-1:0] iload,
  output logic [1:0]             ccwait,
  output logic [1:0][ADDR_W-1:0] ccsnoopaddr,
  output logic [1:0]             ccinv,
  output logic                   ramREN,
  output logic                   ramWEN,
  output logic [ADDR_W-1:0]      ramaddr,
  output logic [ADDR_W-1:0]      ramstore
`ifdef BUS_STATS_EN
  ,
  output logic [31:0]            c2c_cnt,
  output logic [31:0]            ram_rd_cnt,
  output logic [31:0]            ram_wr_cnt
`endif
);

  localparam logic [3:0] S_IDLE   = 4'd0;
  localparam logic [3:0] S_ARB    = 4'd1;
  localparam logic [3:0] S_SNOOP  = 4'd2;
  localparam logic [3:0] S_C2C0   = 4'd3;
  localparam logic [3:0] S_C2C1   = 4'd4;
  localparam logic [3:0] S_RD0    = 4'd5;
  localparam logic [3:0] S_RD1    = 4'd6;
  localparam logic [3:0] S_WB0    = 4'd7;
  localparam logic [3:0] S_WB1    = 4'd8;
  localparam logic [3:0] S_IFETCH = 4'd9;

  logic [3:0] r_state;
  logic [3:0] w_state_next;
  logic       r_prio;       // core that wins a tie within a request class
  logic       r_req;        // latched requester for the current transaction
  logic       r_inv;        // latched ccwrite of the requester
  logic       r_snoop_2nd;  // set during the second SNOOP cycle

  logic       w_snp;
  logic       w_done;
  logic       w_txn_done;
  logic       w_snoop_phase;

  // Per-core request classes.
  logic [1:0] w_wb_req;
  logic [1:0] w_cc_req;
  logic [1:0] w_if_req;
  logic       w_any_req;
  logic       w_sel_core;
  logic [3:0] w_sel_state;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_req
      // A dcache write without a coherence transaction is an eviction/flush.
      assign w_wb_req[gi] = dWEN[gi] & ~cctrans[gi];
      assign w_cc_req[gi] = cctrans[gi] & (dREN[gi] | dWEN[gi]);
      assign w_if_req[gi] = iREN[gi];
    end
  endgenerate

  assign w_any_req = |{w_wb_req, w_cc_req, w_if_req};
  assign w_snp     = ~r_req;
  assign w_done    = ~ramwait;

  assign w_snoop_phase = (r_state == S_SNOOP) || (r_state == S_C2C0) ||
                         (r_state == S_C2C1)  || (r_state == S_RD0)  ||
                         (r_state == S_RD1);

  assign w_txn_done = w_done && ((r_state == S_WB1)  || (r_state == S_C2C1) ||
                                 (r_state == S_RD1)  || (r_state == S_IFETCH));

  // Class priority first (writeback > coherence > ifetch), then core priority.
  always_comb begin
    w_sel_core  = r_prio;
    w_sel_state = S_IDLE;
    if (|w_wb_req) begin
      w_sel_core  = w_wb_req[r_prio] ? r_prio : ~r_prio;
      w_sel_state = S_WB0;
    end else if (|w_cc_req) begin
      w_sel_core  = w_cc_req[r_prio] ? r_prio : ~r_prio;
      w_sel_state = S_SNOOP;
    end else if (|w_if_req) begin
      w_sel_core  = w_if_req[r_prio] ? r_prio : ~r_prio;
      w_sel_state = S_IFETCH;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:   if (w_any_req) w_state_next = S_ARB;
      // Requests may have dropped since IDLE; w_sel_state is IDLE then.
      S_ARB:    w_state_next = w_sel_state;
      // The snoopee always gets one full cycle to answer.
      S_SNOOP:  if (r_snoop_2nd) w_state_next = ccwrite[w_snp] ? S_C2C0 : S_RD0;
      S_C2C0:   if (w_done) w_state_next = S_C2C1;
      S_C2C1:   if (w_done) w_state_next = S_IDLE;
      S_RD0:    if (w_done) w_state_next = S_RD1;
      S_RD1:    if (w_done) w_state_next = S_IDLE;
      S_WB0:    if (w_done) w_state_next = S_WB1;
      S_WB1:    if (w_done) w_state_next = S_IDLE;
      S_IFETCH: if (w_done) w_state_next = S_IDLE;
      default:  w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_state     <= S_IDLE;
      r_prio      <= RR_INIT;
      r_req       <= 1'b0;
      r_inv       <= 1'b0;
      r_snoop_2nd <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_snoop_2nd <= (r_state == S_SNOOP) && !r_snoop_2nd;
      if (r_state == S_ARB) begin
        r_req <= w_sel_core;
        r_inv <= ccwrite[w_sel_core];
      end
      if (w_txn_done) begin
        r_prio <= ~r_prio;
      end
    end
  end

  // Outputs are decoded from state so a reset forces them immediately.
  always_comb begin
    dwait       = 2'b11;
    iwait       = 2'b11;
    dload       = '0;
    iload       = '0;
    ccwait      = 2'b00;
    ccsnoopaddr = '0;
    ccinv       = 2'b00;
    ramREN      = 1'b0;
    ramWEN      = 1'b0;
    ramaddr     = '0;
    ramstore    = '0;

    // Snoopee stays stalled from SNOOP until the data phase completes.
    if (w_snoop_phase) begin
      ccwait[w_snp]      = 1'b1;
      ccsnoopaddr[w_snp] = daddr[r_req];
      ccinv[w_snp]       = r_inv;
    end

    case (r_state)
      S_WB0, S_WB1: begin
        ramWEN   = 1'b1;
        ramaddr  = daddr[r_req];
        ramstore = dstore[r_req];
        dwait[r_req] = ~w_done;
      end
      S_C2C0, S_C2C1: begin
        // Dirty peer data goes to the requester and to RAM in the same cycle.
        ramWEN       = 1'b1;
        ramaddr      = daddr[w_snp];
        ramstore     = dstore[w_snp];
        dload[r_req] = dstore[w_snp];
        dwait[r_req] = ~w_done;
        dwait[w_snp] = ~w_done;
      end
      S_RD0, S_RD1: begin
        ramREN       = 1'b1;
        ramaddr      = daddr[r_req];
        dload[r_req] = ramload;
        dwait[r_req] = ~w_done;
      end
      S_IFETCH: begin
        ramREN       = 1'b1;
        ramaddr      = iaddr[r_req];
        iload[r_req] = ramload;
        iwait[r_req] = ~w_done;
      end
      default: begin
      end
    endcase
  end

`ifdef BUS_STATS_EN
  logic [31:0] r_c2c_cnt;
  logic [31:0] r_ram_rd_cnt;
  logic [31:0] r_ram_wr_cnt;
  logic        w_c2c_word;
  logic        w_rd_word;
  logic        w_wr_word;

  assign w_c2c_word = w_done && ((r_state == S_C2C0) || (r_state == S_C2C1));
  assign w_rd_word  = w_done && ((r_state == S_RD0) || (r_state == S_RD1) ||
                                 (r_state == S_IFETCH));
  assign w_wr_word  = w_done && ((r_state == S_WB0) || (r_state == S_WB1) ||
                                 (r_state == S_C2C0) || (r_state == S_C2C1));

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_c2c_cnt    <= '0;
      r_ram_rd_cnt <= '0;
      r_ram_wr_cnt <= '0;
    end else begin
      if (w_c2c_word && (r_c2c_cnt != '1))    r_c2c_cnt    <= r_c2c_cnt + 32'd1;
      if (w_rd_word  && (r_ram_rd_cnt != '1)) r_ram_rd_cnt <= r_ram_rd_cnt + 32'd1;
      if (w_wr_word  && (r_ram_wr_cnt != '1)) r_ram_wr_cnt <= r_ram_wr_cnt + 32'd1;
    end
  end

  assign c2c_cnt    = r_c2c_cnt;
  assign ram_rd_cnt = r_ram_rd_cnt;
  assign ram_wr_cnt = r_ram_wr_cnt;
`endif

endmodule

// File: tb/tb_coherence_bus_ctrl.sv
// ---------------------------------------------------------------------------
// tb_coherence_bus_ctrl
//
// Scoreboard bench for coherence_bus_ctrl. The bench acts as both cores and
// the RAM. Expected dload/iload words and RAM writes are queued when a
// transaction is started. A negedge monitor pops and compares them whenever
// the DUT completes a word.
// ---------------------------------------------------------------------------
module tb_coherence_bus_ctrl;

  logic             CLK;
  logic             nRST;
  logic [1:0]       dREN, dWEN, cctrans, ccwrite, iREN;
  logic [1:0][31:0] daddr, dstore, iaddr;
  logic [31:0]      ramload;
  logic             ramwait;
  logic [1:0]       dwait, iwait, ccwait, ccinv;
  logic [1:0][31:0] dload, iload, ccsnoopaddr;
  logic             ramREN, ramWEN;
  logic [31:0]      ramaddr, ramstore;
`ifdef BUS_STATS_EN
  logic [31:0]      c2c_cnt, ram_rd_cnt, ram_wr_cnt;
`endif

  coherence_bus_ctrl #(.ADDR_W(32), .RR_INIT(1'b0)) dut (
    .CLK(CLK), .nRST(nRST),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .cctrans(cctrans), .ccwrite(ccwrite),
    .iREN(iREN), .iaddr(iaddr),
    .ramload(ramload), .ramwait(ramwait),
    .dwait(dwait), .iwait(iwait), .dload(dload), .iload(iload),
    .ccwait(ccwait), .ccsnoopaddr(ccsnoopaddr), .ccinv(ccinv),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore)
`ifdef BUS_STATS_EN
    , .c2c_cnt(c2c_cnt), .ram_rd_cnt(ram_rd_cnt), .ram_wr_cnt(ram_wr_cnt)
`endif
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // RAM model: unwritten words read as a fixed function of their address.
  logic [31:0]   mem [0:1023];
  logic [1023:0] wr_valid = '0;

  function automatic logic [31:0] ram_init(input logic [31:0] a);
    return 32'hC0DE_0000 ^ a;
  endfunction

  assign ramload = wr_valid[ramaddr[11:2]] ? mem[ramaddr[11:2]] : ram_init(ramaddr);

  always @(posedge CLK) begin
    if (nRST && ramWEN && !ramwait) begin
      mem[ramaddr[11:2]]      <= ramstore;
      wr_valid[ramaddr[11:2]] <= 1'b1;
    end
  end

  // Scoreboard
  typedef struct packed {
    logic [31:0] d;
    logic        chk;
  } exp_t;

  exp_t        dq0[$], dq1[$], iq0[$], iq1[$];
  logic [63:0] wq[$];
  int          n_tests = 0;
  int          n_fail  = 0;
  int          ccw1_cnt = 0;
  exp_t        mon_e;
  logic [63:0] mon_w;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(negedge CLK) begin
    if (nRST) begin
      check("ram_strobes_excl", {63'd0, ramREN & ramWEN}, 64'd0);
      if (ccwait[1]) ccw1_cnt++;
      if (!dwait[0]) begin
        check("dq0_pending", {63'd0, dq0.size() > 0}, 64'd1);
        if (dq0.size() > 0) begin
          mon_e = dq0.pop_front();
          if (mon_e.chk) check("dload0", {32'd0, dload[0]}, {32'd0, mon_e.d});
        end
      end
      if (!dwait[1]) begin
        check("dq1_pending", {63'd0, dq1.size() > 0}, 64'd1);
        if (dq1.size() > 0) begin
          mon_e = dq1.pop_front();
          if (mon_e.chk) check("dload1", {32'd0, dload[1]}, {32'd0, mon_e.d});
        end
      end
      if (!iwait[0]) begin
        check("iq0_pending", {63'd0, iq0.size() > 0}, 64'd1);
        if (iq0.size() > 0) begin
          mon_e = iq0.pop_front();
          check("iload0", {32'd0, iload[0]}, {32'd0, mon_e.d});
        end
      end
      if (!iwait[1]) begin
        check("iq1_pending", {63'd0, iq1.size() > 0}, 64'd1);
        if (iq1.size() > 0) begin
          mon_e = iq1.pop_front();
          check("iload1", {32'd0, iload[1]}, {32'd0, mon_e.d});
        end
      end
      if (ramWEN && !ramwait) begin
        check("wq_pending", {63'd0, wq.size() > 0}, 64'd1);
        if (wq.size() > 0) begin
          mon_w = wq.pop_front();
          check("ram_write", {ramaddr, ramstore}, mon_w);
        end
      end
    end
  end

  // Helpers
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  function automatic logic sig_active(input int sel, input int c);
    case (sel)
      0:       return !dwait[c];
      1:       return !iwait[c];
      2:       return ccwait[c];
      default: return ramREN;
    endcase
  endfunction

  // Waits (bounded) for a negedge at which the selected signal is active.
  task automatic wait_for(input int sel, input int c, input string tag);
    int n;
    n = 0;
    do begin
      @(negedge CLK);
      n++;
    end while (n < 200 && !sig_active(sel, c));
    check(tag, {63'd0, sig_active(sel, c)}, 64'd1);
  endtask

  task automatic drop_all();
    dREN = 2'b00; dWEN = 2'b00; cctrans = 2'b00; ccwrite = 2'b00; iREN = 2'b00;
    daddr = '0; dstore = '0; iaddr = '0;
  endtask

  task automatic check_reset(input string pfx);
    check({pfx, "_dwait"},  {62'd0, dwait},  64'd3);
    check({pfx, "_iwait"},  {62'd0, iwait},  64'd3);
    check({pfx, "_ccwait"}, {62'd0, ccwait}, 64'd0);
    check({pfx, "_ccinv"},  {62'd0, ccinv},  64'd0);
    check({pfx, "_snpadr"}, ccsnoopaddr,     64'd0);
    check({pfx, "_ramREN"}, {63'd0, ramREN}, 64'd0);
    check({pfx, "_ramWEN"}, {63'd0, ramWEN}, 64'd0);
    check({pfx, "_raddr"},  {32'd0, ramaddr},  64'd0);
    check({pfx, "_rstore"}, {32'd0, ramstore}, 64'd0);
    check({pfx, "_dload"},  dload, 64'd0);
    check({pfx, "_iload"},  iload, 64'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int snap;

  initial begin
    nRST = 1'b0;
    ramwait = 1'b0;
    drop_all();
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    check_reset("reset");
    step();
    nRST = 1'b1;
    step();

    // 1: core0 read miss @0x100, core1 clean -> RAM read of two words
    snap = ccw1_cnt;
    dq0.push_back({ram_init(32'h100), 1'b1});
    dq0.push_back({ram_init(32'h104), 1'b1});
    dREN[0] = 1'b1; cctrans[0] = 1'b1; daddr[0] = 32'h100;
    wait_for(2, 1, "t1_ccwait1");
    check("t1_snpaddr1", {32'd0, ccsnoopaddr[1]}, 64'h100);
    check("t1_ccinv1", {63'd0, ccinv[1]}, 64'd0);
    wait_for(0, 0, "t1_word0");
    step();
    daddr[0] = 32'h104;
    wait_for(0, 0, "t1_word1");
    step();
    drop_all();
    @(negedge CLK);
    check("t1_ccwait_drop", {62'd0, ccwait}, 64'd0);
    check("t1_ccwait_len", {63'd0, (ccw1_cnt - snap) >= 4}, 64'd1);
    $display("[TB] t1 read miss core0 done");

    // 2: core1 read-exclusive @0x200, core0 supplies dirty data
    dq1.push_back({32'hDEAD, 1'b1});
    dq1.push_back({32'hBEEF, 1'b1});
    dq0.push_back({32'h0, 1'b0});
    dq0.push_back({32'h0, 1'b0});
    wq.push_back({32'h200, 32'hDEAD});
    wq.push_back({32'h204, 32'hBEEF});
    step();
    dREN[1] = 1'b1; cctrans[1] = 1'b1; ccwrite[1] = 1'b1; daddr[1] = 32'h200;
    wait_for(2, 0, "t2_ccwait0");
    check("t2_ccinv0", {63'd0, ccinv[0]}, 64'd1);
    check("t2_snpaddr0", {32'd0, ccsnoopaddr[0]}, 64'h200);
    step();
    ccwrite[0] = 1'b1; dWEN[0] = 1'b1; daddr[0] = 32'h200; dstore[0] = 32'hDEAD;
    wait_for(0, 1, "t2_word0");
    step();
    daddr[0] = 32'h204; dstore[0] = 32'hBEEF; daddr[1] = 32'h204;
    wait_for(0, 1, "t2_word1");
    step();
    drop_all();
    @(negedge CLK);
    check("t2_ram200", {32'd0, mem[32'h200 >> 2]}, 64'hDEAD);
    check("t2_ram204", {32'd0, mem[32'h204 >> 2]}, 64'hBEEF);
`ifdef BUS_STATS_EN
    check("stats_c2c", {32'd0, c2c_cnt}, 64'd2);
    check("stats_rd",  {32'd0, ram_rd_cnt}, 64'd2);
    check("stats_wr",  {32'd0, ram_wr_cnt}, 64'd2);
`endif
    $display("[TB] t2 c2c read-excl core1 done");

    // 3: both cores miss together, prio=0 -> core0 first, then core1
    dq0.push_back({ram_init(32'h300), 1'b1});
    dq0.push_back({ram_init(32'h304), 1'b1});
    dq1.push_back({ram_init(32'h400), 1'b1});
    dq1.push_back({ram_init(32'h404), 1'b1});
    step();
    dREN = 2'b11; cctrans = 2'b11; daddr[0] = 32'h300; daddr[1] = 32'h400;
    wait_for(2, 1, "t3_first_snoop");
    check("t3_first_ccwait", {62'd0, ccwait}, 64'd2);
    wait_for(0, 0, "t3_c0_word0");
    step();
    daddr[0] = 32'h304;
    wait_for(0, 0, "t3_c0_word1");
    step();
    dREN[0] = 1'b0; cctrans[0] = 1'b0; daddr[0] = 32'h0;
    wait_for(2, 0, "t3_second_snoop");
    check("t3_second_ccwait", {62'd0, ccwait}, 64'd1);
    check("t3_snpaddr0", {32'd0, ccsnoopaddr[0]}, 64'h400);
    wait_for(0, 1, "t3_c1_word0");
    step();
    daddr[1] = 32'h404;
    wait_for(0, 1, "t3_c1_word1");
    step();
    drop_all();
    $display("[TB] t3 simultaneous misses done");

    // 4: core0 evicts while core1 fetches -> writeback first, then ifetch
    wq.push_back({32'h500, 32'hA1});
    wq.push_back({32'h504, 32'hA2});
    dq0.push_back({32'h0, 1'b0});
    dq0.push_back({32'h0, 1'b0});
    iq1.push_back({ram_init(32'h600), 1'b1});
    step();
    dWEN[0] = 1'b1; daddr[0] = 32'h500; dstore[0] = 32'hA1;
    iREN[1] = 1'b1; iaddr[1] = 32'h600;
    wait_for(0, 0, "t4_wb0");
    check("t4_if_pending", {32'd0, iq1.size()}, 64'd1);
    step();
    daddr[0] = 32'h504; dstore[0] = 32'hA2;
    wait_for(0, 0, "t4_wb1");
    check("t4_if_after_wb", {32'd0, iq1.size()}, 64'd1);
    step();
    dWEN[0] = 1'b0; daddr[0] = 32'h0; dstore[0] = 32'h0;
    wait_for(1, 1, "t4_ifetch");
    step();
    drop_all();
    @(negedge CLK);
    check("t4_iwait_idle", {62'd0, iwait}, 64'd3);
    $display("[TB] t4 writeback then ifetch done");

    // 5: RAM stalls for 10 cycles in RD0 -> outputs hold
    ramwait = 1'b1;
    dq0.push_back({ram_init(32'h700), 1'b1});
    dq0.push_back({ram_init(32'h704), 1'b1});
    dREN[0] = 1'b1; cctrans[0] = 1'b1; daddr[0] = 32'h700;
    wait_for(3, 0, "t5_rd0");
    for (int k = 0; k < 10; k++) begin
      check("t5_hold_ctl", {54'd0, dwait, iwait, ccwait, ccinv, ramREN, ramWEN},
            {54'd0, 10'b11_11_10_00_1_0});
      check("t5_hold_addr", {32'd0, ramaddr}, 64'h700);
      @(negedge CLK);
    end
    step();
    ramwait = 1'b0;
    wait_for(0, 0, "t5_word0");
    step();
    daddr[0] = 32'h704;
    wait_for(0, 0, "t5_word1");
    step();
    drop_all();
    $display("[TB] t5 ram stall done");

    // 6: reset asserted while in C2C1
    dq0.push_back({32'hC1, 1'b1});
    dq1.push_back({32'h0, 1'b0});
    wq.push_back({32'h800, 32'hC1});
    step();
    dREN[0] = 1'b1; cctrans[0] = 1'b1; ccwrite[0] = 1'b1; daddr[0] = 32'h800;
    wait_for(2, 1, "t6_ccwait1");
    check("t6_ccinv1", {63'd0, ccinv[1]}, 64'd1);
    step();
    ccwrite[1] = 1'b1; dWEN[1] = 1'b1; daddr[1] = 32'h800; dstore[1] = 32'hC1;
    wait_for(0, 0, "t6_word0");
    step();
    daddr[0] = 32'h804; daddr[1] = 32'h804; dstore[1] = 32'hC2;
    nRST = 1'b0;
    @(negedge CLK);
    check_reset("t6_rst");
    step();
    drop_all();
    step();
    nRST = 1'b1;
    repeat (4) step();
    @(negedge CLK);
    check("t6_no_partial_wr", {63'd0, wr_valid[32'h804 >> 2]}, 64'd0);
    check("sb_drained",
          {32'd0, dq0.size() + dq1.size() + iq0.size() + iq1.size() + wq.size()}, 64'd0);
    $display("[TB] t6 reset mid-transaction done");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
